// File: rtl/rr_burst_arbiter.sv
// -----------------------------------------------------------------------------
// rr_burst_arbiter
//   Round-robin arbiter that drives the pop/grant vector of a FIFO bank.
//   A FIFO that wins arbitration may keep the grant for up to BURST
//   consecutive pops. After that, the search restarts from the FIFO after the
//   owner. Only requesters that are not empty are eligible. A downstream stall
//   suppresses all grants and freezes the arbitration state.
//
//   Handshake: gnt is the pop strobe. A FIFO is popped in exactly those
//   cycles where its gnt bit is 1. gnt is already 0 whenever stall=1, so
//   consumers can use gnt directly, without qualifying it with stall.
//
// Ports
//   clk        clock
//   rst        synchronous, active-high reset
//   reqs       per-FIFO request
//   empty      per-FIFO empty flag
//   stall      downstream not ready; forces gnt=0 and holds all state
//   gnt        one-hot (or zero) grant, combinational from the inputs
//   gnt_vld    |gnt
//   gnt_idx    binary index of the granted FIFO, 0 when nothing is granted
//   burst_cnt  grants issued in the current burst (registered)
// -----------------------------------------------------------------------------
module rr_burst_arbiter #(
  parameter int NUM_FIFOS = 4,
  parameter int BURST     = 2,
  parameter int TAGWIDTH  = $clog2(NUM_FIFOS),
  parameter int CNTWIDTH  = $clog2(BURST + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_FIFOS-1:0] reqs,
  input  logic [NUM_FIFOS-1:0] empty,
  input  logic                 stall,
  output logic [NUM_FIFOS-1:0] gnt,
  output logic                 gnt_vld,
  output logic [TAGWIDTH-1:0]  gnt_idx,
  output logic [CNTWIDTH-1:0]  burst_cnt
);

  localparam logic [CNTWIDTH-1:0] BURST_C = CNTWIDTH'(BURST);
  localparam logic [CNTWIDTH-1:0] ONE_C   = CNTWIDTH'(1);
  localparam logic [TAGWIDTH-1:0] LAST_C  = TAGWIDTH'(NUM_FIFOS - 1);

  // ST_BURST means the FIFO at ptr_q holds a burst that may still continue.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [TAGWIDTH-1:0]   ptr_q, ptr_d;
  logic [CNTWIDTH-1:0]   cnt_q, cnt_d;

  logic [NUM_FIFOS-1:0]  eligible;
  logic                  cont;
  logic                  found;
  logic [TAGWIDTH-1:0]   sel;
  logic                  block;
  int                    idx;

  assign eligible = reqs & ~empty;

  // Rotating search: candidates are ptr+1, ptr+2, ... and ptr itself comes
  // last. The last owner is therefore chosen again only when no other FIFO
  // is eligible.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_FIFOS; k++) begin
      idx = (int'(ptr_q) + k) % NUM_FIFOS;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        sel   = TAGWIDTH'(idx);
      end
    end
  end

  // Grant selection and next-state logic.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;

    block = rst | stall | ~(|eligible);
    cont  = (state_q == ST_BURST) && eligible[ptr_q] && (cnt_q < BURST_C);

    if (!block) begin
      gnt_idx      = cont ? ptr_q : sel;
      gnt[gnt_idx] = 1'b1;
    end

    if (!stall) begin
      if (!block && cont) begin
        cnt_d = cnt_q + ONE_C;
      end else if (!block) begin
        ptr_d   = sel;
        cnt_d   = ONE_C;
        state_d = ST_BURST;
      end else begin
        // No grant this cycle: the burst ends. ptr is kept so that the
        // rotation resumes after the previous owner.
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    end
  end

  assign gnt_vld   = |gnt;
  assign burst_cnt = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= LAST_C;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FORMAL
  localparam int WAIT_MAX = (NUM_FIFOS - 1) * BURST;

  // Counts the non-stall cycles that each FIFO has spent eligible but
  // not granted.
  int wait_cnt [NUM_FIFOS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FIFOS; i++) begin
      if (rst || !eligible[i] || gnt[i]) begin
        wait_cnt[i] <= 0;
      end else if (!stall) begin
        wait_cnt[i] <= wait_cnt[i] + 1;
      end
    end
  end

  always @(posedge clk) begin
    assert ($onehot0(gnt));
    assert ((gnt & ~eligible) == '0);
    assert (!((|eligible) && !stall && !rst) || (gnt != '0));
    assert (cnt_q <= BURST_C);
    for (int i = 0; i < NUM_FIFOS; i++) begin
      assert (wait_cnt[i] <= WAIT_MAX);
    end
  end
`endif

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_burst_arbiter
//   Self-checking bench for rr_burst_arbiter (NUM_FIFOS=4, BURST=2).
//   Inputs are driven after the falling edge. Combinational outputs are
//   sampled 1 time unit later. burst_cnt is sampled 1 time unit after the
//   rising edge.
// -----------------------------------------------------------------------------
module tb_rr_burst_arbiter;

  localparam int N     = 4;
  localparam int BURST = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] reqs;
  logic [N-1:0] empty;
  logic         stall;
  logic [N-1:0] gnt;
  logic         gnt_vld;
  logic [1:0]   gnt_idx;
  logic [1:0]   burst_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model in abstract terms. It tracks the owner of the last
  // grant, the number of grants that owner has taken in its burst, and
  // whether that burst is still alive.
  int m_owner = N - 1;
  int m_taken = 0;
  bit m_alive = 1'b0;

  rr_burst_arbiter #(.NUM_FIFOS(N), .BURST(BURST)) dut (
    .clk       (clk),
    .rst       (rst),
    .reqs      (reqs),
    .empty     (empty),
    .stall     (stall),
    .gnt       (gnt),
    .gnt_vld   (gnt_vld),
    .gnt_idx   (gnt_idx),
    .burst_cnt (burst_cnt)
  );

  always #5 clk = ~clk;

  // Returns the FIFO that should be granted for the current inputs,
  // or -1 when nothing should be granted.
  function automatic int model_pick();
    logic [N-1:0] el;
    el = reqs & ~empty;
    if (rst || stall || el == '0) return -1;
    if (m_alive && el[m_owner] && m_taken < BURST) return m_owner;
    for (int k = 1; k <= N; k++) begin
      if (el[(m_owner + k) % N]) return (m_owner + k) % N;
    end
    return -1;
  endfunction

  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] e,
                       input logic s, input logic rs);
    @(negedge clk);
    reqs  = r;
    empty = e;
    stall = s;
    rst   = rs;
    #1;
  endtask

  // Advances one clock and moves the model forward with it.
  task automatic tick();
    int           p;
    bit           keep;
    logic [N-1:0] el;
    el   = reqs & ~empty;
    p    = model_pick();
    keep = (p >= 0) && m_alive && el[m_owner] && (m_taken < BURST);
    @(posedge clk);
    if (rst) begin
      m_owner = N - 1;
      m_taken = 0;
      m_alive = 1'b0;
    end else if (!stall) begin
      if (p < 0) begin
        m_taken = 0;
        m_alive = 1'b0;
      end else if (keep) begin
        m_taken++;
      end else begin
        m_owner = p;
        m_taken = 1;
        m_alive = 1'b1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    drive('0, '0, 1'b0, 1'b1);
    tick();
    drive('0, '0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      drive(4'b1111, 4'b0000, 1'b0, 1'b1);
      checks++;
      if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || gnt_idx !== 2'd0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: got gnt=%b vld=%b idx=%0d, want 0/0/0",
                 k, gnt, gnt_vld, gnt_idx);
      end
      tick();
      checks++;
      if (burst_cnt !== 2'd0) begin
        errors++;
        $display("FAIL reset_burst_cnt[%0d]: got %0d, want 0", k, burst_cnt);
      end
    end
  endtask

  task automatic test_full_rotation();
    logic [3:0] exp_g [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                              4'b0100, 4'b1000, 4'b1000, 4'b0001};
    logic [1:0] exp_c [9] = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1};
    do_reset();
    for (int k = 0; k < 9; k++) begin
      drive(4'b1111, 4'b0000, 1'b0, 1'b0);
      checks++;
      if (gnt !== exp_g[k]) begin
        errors++;
        $display("FAIL rotation_gnt[%0d]: got %b, want %b", k, gnt, exp_g[k]);
      end
      tick();
      checks++;
      if (burst_cnt !== exp_c[k]) begin
        errors++;
        $display("FAIL rotation_cnt[%0d]: got %0d, want %0d", k, burst_cnt, exp_c[k]);
      end
    end
  endtask

  task automatic test_empty_skip();
    logic [3:0] exp_g [5] = '{4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b0010};
    logic [1:0] exp_i [5] = '{2'd1, 2'd1, 2'd3, 2'd3, 2'd1};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(4'b1111, 4'b0101, 1'b0, 1'b0);
      checks++;
      if (gnt !== exp_g[k] || gnt_idx !== exp_i[k]) begin
        errors++;
        $display("FAIL empty_skip[%0d]: got gnt=%b idx=%0d, want %b idx=%0d",
                 k, gnt, gnt_idx, exp_g[k], exp_i[k]);
      end
      tick();
    end
  endtask

  task automatic test_owner_drop();
    do_reset();
    drive(4'b1111, 4'b0000, 1'b0, 1'b0);
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL drop_first: got %b, want 0001", gnt);
    end
    tick();
    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    checks++;
    if (gnt !== 4'b0000 || gnt_vld !== 1'b0) begin
      errors++;
      $display("FAIL drop_idle: got gnt=%b vld=%b, want 0000/0", gnt, gnt_vld);
    end
    tick();
    checks++;
    if (burst_cnt !== 2'd0) begin
      errors++;
      $display("FAIL drop_cnt: got %0d, want 0", burst_cnt);
    end
    drive(4'b0011, 4'b0000, 1'b0, 1'b0);
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL drop_resume: got %b, want 0010", gnt);
    end
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    drive(4'b1111, 4'b0000, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(4'b1111, 4'b0000, 1'b1, 1'b0);
      checks++;
      if (gnt !== 4'b0000) begin
        errors++;
        $display("FAIL stall_gnt[%0d]: got %b, want 0000", k, gnt);
      end
      tick();
      checks++;
      if (burst_cnt !== 2'd1) begin
        errors++;
        $display("FAIL stall_cnt[%0d]: got %0d, want 1", k, burst_cnt);
      end
    end
    drive(4'b1111, 4'b0000, 1'b0, 1'b0);
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL stall_resume: got %b, want 0001", gnt);
    end
    tick();
    checks++;
    if (burst_cnt !== 2'd2) begin
      errors++;
      $display("FAIL stall_resume_cnt: got %0d, want 2", burst_cnt);
    end
    drive(4'b1111, 4'b0000, 1'b0, 1'b0);
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL stall_rotate: got %b, want 0010", gnt);
    end
    tick();
  endtask

  task automatic test_sole_requester();
    logic [1:0] exp_c [5] = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(4'b1000, 4'b0000, 1'b0, 1'b0);
      checks++;
      if (gnt !== 4'b1000) begin
        errors++;
        $display("FAIL sole_gnt[%0d]: got %b, want 1000", k, gnt);
      end
      tick();
      checks++;
      if (burst_cnt !== exp_c[k]) begin
        errors++;
        $display("FAIL sole_cnt[%0d]: got %0d, want %0d", k, burst_cnt, exp_c[k]);
      end
    end
  endtask

  task automatic test_mid_burst_reset();
    logic [3:0] exp_g [5] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(4'b1111, 4'b0000, 1'b0, 1'b0);
      checks++;
      if (gnt !== exp_g[k]) begin
        errors++;
        $display("FAIL pre_reset_gnt[%0d]: got %b, want %b", k, gnt, exp_g[k]);
      end
      tick();
    end
    checks++;
    if (burst_cnt !== 2'd1) begin
      errors++;
      $display("FAIL pre_reset_cnt: got %0d, want 1", burst_cnt);
    end
    drive(4'b1111, 4'b0000, 1'b0, 1'b1);
    checks++;
    if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || gnt_idx !== 2'd0) begin
      errors++;
      $display("FAIL in_reset: got gnt=%b vld=%b idx=%0d, want 0/0/0",
               gnt, gnt_vld, gnt_idx);
    end
    tick();
    drive(4'b1111, 4'b0000, 1'b0, 1'b0);
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL post_reset_gnt: got %b, want 0001", gnt);
    end
    tick();
    checks++;
    if (burst_cnt !== 2'd1) begin
      errors++;
      $display("FAIL post_reset_cnt: got %0d, want 1", burst_cnt);
    end
  endtask

  task automatic test_random();
    int           p;
    int           waits [N];
    logic [N-1:0] exp_g;
    logic [1:0]   exp_i;
    logic [N-1:0] el;
    logic [N-1:0] r, e;
    logic         s, rs;
    do_reset();
    for (int i = 0; i < N; i++) waits[i] = 0;
    for (int k = 0; k < 600; k++) begin
      r  = N'($urandom_range(0, 15));
      e  = N'($urandom_range(0, 15) & $urandom_range(0, 15));
      s  = ($urandom_range(0, 9) < 2);
      rs = ($urandom_range(0, 99) < 2);
      drive(r, e, s, rs);
      p     = model_pick();
      exp_g = (p < 0) ? '0 : (N'(1) << p);
      exp_i = (p < 0) ? 2'd0 : p[1:0];
      checks++;
      if (gnt !== exp_g || gnt_idx !== exp_i || gnt_vld !== (p >= 0)) begin
        errors++;
        $display("FAIL rand_grant[%0d]: got gnt=%b idx=%0d vld=%b, want %b idx=%0d vld=%b",
                 k, gnt, gnt_idx, gnt_vld, exp_g, exp_i, (p >= 0));
      end
      el = r & ~e;
      for (int i = 0; i < N; i++) begin
        if (rs || !el[i] || gnt[i]) waits[i] = 0;
        else if (!s) waits[i]++;
        checks++;
        if (waits[i] > (N - 1) * BURST) begin
          errors++;
          $display("FAIL rand_fairness[%0d]: fifo %0d waited %0d, limit %0d",
                   k, i, waits[i], (N - 1) * BURST);
        end
      end
      tick();
      checks++;
      if (burst_cnt !== 2'(m_taken)) begin
        errors++;
        $display("FAIL rand_cnt[%0d]: got %0d, want %0d", k, burst_cnt, m_taken);
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    reqs  = '0;
    empty = '0;
    stall = 1'b0;
    test_reset();
    test_full_rotation();
    test_empty_skip();
    test_owner_drop();
    test_stall();
    test_sole_requester();
    test_mid_burst_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
